// File: rtl/memwb_pkg.sv
// Shared configuration for the memory/writeback stage: widths and FSM encoding.
package memwb_pkg;

  localparam int MEMWB_RW    = 16;
  localparam int MEMWB_REGNO = 8;

  typedef enum logic {
    MEMWB_IDLE = 1'b0,
    MEMWB_WAIT = 1'b1
  } memwb_state_e;

endpackage

// File: rtl/memwb_skid.sv
// One-entry op buffer: holds the op execute issued while the stage was already
// waiting on memory, until the stage returns to IDLE.
module memwb_skid
  import memwb_pkg::*;
#(
  parameter int RW    = MEMWB_RW,
  parameter int REGNO = MEMWB_REGNO
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             load,
  input  logic             drain,
  input  logic [RW-1:0]    data,
  input  logic [RW-1:0]    addr,
  input  logic [REGNO-1:0] reg_ie,
  input  logic             mem_access,
  input  logic             mem_we,
  output logic             valid,
  output logic [RW-1:0]    q_data,
  output logic [RW-1:0]    q_addr,
  output logic [REGNO-1:0] q_reg_ie,
  output logic             q_mem_access,
  output logic             q_mem_we
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid        <= 1'b0;
      q_data       <= '0;
      q_addr       <= '0;
      q_reg_ie     <= '0;
      q_mem_access <= 1'b0;
      q_mem_we     <= 1'b0;
    end else if (load) begin
      valid        <= 1'b1;
      q_data       <= data;
      q_addr       <= addr;
      q_reg_ie     <= reg_ie;
      q_mem_access <= mem_access;
      q_mem_we     <= mem_we;
    end else if (drain) begin
      valid        <= 1'b0;
    end
  end

endmodule

// File: rtl/memwb.sv
// Memory/writeback stage: issues loads/stores on the req/ack bus and returns
// the writeback word plus one-hot register enable to the register file.
module memwb
  import memwb_pkg::*;
#(
  parameter int RW    = MEMWB_RW,
  parameter int REGNO = MEMWB_REGNO
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [RW-1:0]    i_data,
  input  logic [RW-1:0]    i_addr,
  input  logic [REGNO-1:0] i_reg_ie,
  input  logic             i_mem_access,
  input  logic             i_mem_we,
  input  logic             i_submit,
  output logic             o_ready,
  output logic [REGNO-1:0] o_reg_ie,
  output logic [RW-1:0]    o_reg_data,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [RW-1:0]    o_mem_addr,
  output logic [RW-1:0]    o_mem_data,
  input  logic             i_mem_ack,
  input  logic [RW-1:0]    i_mem_data
);

  memwb_state_e     state, state_nxt;
  logic [REGNO-1:0] pend_ie;

  logic             skid_valid, skid_load, skid_drain;
  logic [RW-1:0]    skid_data, skid_addr;
  logic [REGNO-1:0] skid_reg_ie;
  logic             skid_mem_access, skid_mem_we;

  logic             src_valid, src_mem_access, src_mem_we, take;
  logic [RW-1:0]    src_data, src_addr;
  logic [REGNO-1:0] src_reg_ie;

  // Skid entry is always older than the live inputs, so it wins the source mux.
  always_comb begin
    src_valid      = skid_valid | i_submit;
    src_data       = skid_valid ? skid_data       : i_data;
    src_addr       = skid_valid ? skid_addr       : i_addr;
    src_reg_ie     = skid_valid ? skid_reg_ie     : i_reg_ie;
    src_mem_access = skid_valid ? skid_mem_access : i_mem_access;
    src_mem_we     = skid_valid ? skid_mem_we     : i_mem_we;
  end

  assign o_ready    = (state == MEMWB_IDLE) & ~skid_valid;
  assign take       = (state == MEMWB_IDLE) & src_valid;
  assign skid_load  = (state == MEMWB_WAIT) & i_submit;
  assign skid_drain = (state == MEMWB_IDLE) & skid_valid;

  memwb_skid #(.RW(RW), .REGNO(REGNO)) u_skid (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .load         (skid_load),
    .drain        (skid_drain),
    .data         (i_data),
    .addr         (i_addr),
    .reg_ie       (i_reg_ie),
    .mem_access   (i_mem_access),
    .mem_we       (i_mem_we),
    .valid        (skid_valid),
    .q_data       (skid_data),
    .q_addr       (skid_addr),
    .q_reg_ie     (skid_reg_ie),
    .q_mem_access (skid_mem_access),
    .q_mem_we     (skid_mem_we)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= MEMWB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEMWB_IDLE: if (take && src_mem_access) state_nxt = MEMWB_WAIT;
      MEMWB_WAIT: if (i_mem_ack)              state_nxt = MEMWB_IDLE;
      default:                                state_nxt = MEMWB_IDLE;
    endcase
  end

  // o_reg_ie defaults to 0 every cycle so each writeback is a single pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_reg_ie   <= '0;
      o_reg_data <= '0;
      o_mem_req  <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      pend_ie    <= '0;
    end else begin
      o_reg_ie <= '0;
      case (state)
        MEMWB_IDLE: begin
          if (take) begin
            if (src_mem_access) begin
              o_mem_req  <= 1'b1;
              o_mem_we   <= src_mem_we;
              o_mem_addr <= src_addr;
              o_mem_data <= src_data;
              pend_ie    <= src_reg_ie;
            end else begin
              o_reg_ie   <= src_reg_ie;
              o_reg_data <= src_data;
            end
          end
        end
        MEMWB_WAIT: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            if (!o_mem_we) begin
              o_reg_ie   <= pend_ie;
              o_reg_data <= i_mem_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Execute must never submit while the skid is occupied.
  a_no_skid_overrun: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_submit && skid_valid));

endmodule

// File: tb/tb_memwb.sv
// Scoreboard bench for memwb: expected writebacks are queued at submit/ack
// time and matched in order against every o_reg_ie pulse.
module tb_memwb;
  localparam int RW    = 16;
  localparam int REGNO = 8;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [RW-1:0]    i_data, i_addr, i_mem_data;
  logic [REGNO-1:0] i_reg_ie;
  logic             i_mem_access, i_mem_we, i_submit, i_mem_ack;
  logic             o_ready, o_mem_req, o_mem_we;
  logic [REGNO-1:0] o_reg_ie;
  logic [RW-1:0]    o_reg_data, o_mem_addr, o_mem_data;

  logic [REGNO+RW-1:0] sb[$];
  int ntot  = 0;
  int npass = 0;

  memwb #(.RW(RW), .REGNO(REGNO)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_addr       (i_addr),
    .i_reg_ie     (i_reg_ie),
    .i_mem_access (i_mem_access),
    .i_mem_we     (i_mem_we),
    .i_submit     (i_submit),
    .o_ready      (o_ready),
    .o_reg_ie     (o_reg_ie),
    .o_reg_data   (o_reg_data),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .i_mem_ack    (i_mem_ack),
    .i_mem_data   (i_mem_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic submit(input logic [RW-1:0] d, input logic [RW-1:0] a,
                        input logic [REGNO-1:0] ie, input logic ma, input logic we);
    i_submit = 1'b1; i_data = d; i_addr = a; i_reg_ie = ie;
    i_mem_access = ma; i_mem_we = we;
  endtask

  // Every writeback pulse must match the oldest expected entry.
  always @(negedge i_clk) begin
    if (!i_rst && o_reg_ie != '0) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'(o_reg_ie), 32'h0);
      end else begin
        logic [REGNO+RW-1:0] e;
        e = sb.pop_front();
        chk("wb_ie",   32'(o_reg_ie),   32'(e[REGNO+RW-1:RW]));
        chk("wb_data", 32'(o_reg_data), 32'(e[RW-1:0]));
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_submit = 1'b0; i_data = '0; i_addr = '0; i_reg_ie = '0;
    i_mem_access = 1'b0; i_mem_we = 1'b0; i_mem_ack = 1'b0; i_mem_data = '0;
    cyc(2);
    i_rst = 1'b0;
    chk("rst_ready",    32'(o_ready),    32'h1);
    chk("rst_req",      32'(o_mem_req),  32'h0);
    chk("rst_reg_ie",   32'(o_reg_ie),   32'h0);
    chk("rst_reg_data", 32'(o_reg_data), 32'h0);
    chk("rst_addr",     32'(o_mem_addr), 32'h0);
    chk("rst_we",       32'(o_mem_we),   32'h0);

    // ALU op
    submit(16'h1234, 16'h0, 8'h04, 1'b0, 1'b0);
    sb.push_back({8'h04, 16'h1234});
    cyc(1); i_submit = 1'b0;
    chk("alu_ie",  32'(o_reg_ie),  32'h04);
    chk("alu_req", 32'(o_mem_req), 32'h0);
    cyc(1);
    chk("alu_pulse", 32'(o_reg_ie), 32'h0);

    // Load with ack three cycles after request
    submit(16'h0, 16'h0100, 8'h02, 1'b1, 1'b0);
    cyc(1); i_submit = 1'b0;
    chk("ld_req",   32'(o_mem_req),  32'h1);
    chk("ld_ready", 32'(o_ready),    32'h0);
    chk("ld_ie0",   32'(o_reg_ie),   32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("ld_addr_hold", 32'(o_mem_addr), 32'h0100);
      chk("ld_req_hold",  32'(o_mem_req),  32'h1);
      if (k < 2) cyc(1);
    end
    cyc(1);
    i_mem_ack = 1'b1; i_mem_data = 16'hBEEF;
    sb.push_back({8'h02, 16'hBEEF});
    cyc(1); i_mem_ack = 1'b0;
    chk("ld_req_drop", 32'(o_mem_req), 32'h0);
    chk("ld_ready_up", 32'(o_ready),   32'h1);
    chk("ld_wb_ie",    32'(o_reg_ie),  32'h02);
    cyc(1);

    // Store, ack in first request cycle; reg_ie must be suppressed
    submit(16'h55AA, 16'h0200, 8'h10, 1'b1, 1'b1);
    cyc(1); i_submit = 1'b0;
    chk("st_req",  32'(o_mem_req),  32'h1);
    chk("st_we",   32'(o_mem_we),   32'h1);
    chk("st_addr", 32'(o_mem_addr), 32'h0200);
    chk("st_data", 32'(o_mem_data), 32'h55AA);
    i_mem_ack = 1'b1; i_mem_data = 16'hFFFF;
    cyc(1); i_mem_ack = 1'b0;
    chk("st_req_drop", 32'(o_mem_req), 32'h0);
    chk("st_no_wb",    32'(o_reg_ie),  32'h0);
    cyc(1);

    // Back-to-back: load then ALU op absorbed by the skid
    submit(16'h0, 16'h0010, 8'h01, 1'b1, 1'b0);
    sb.push_back({8'h01, 16'h0A0A});
    cyc(1);
    submit(16'h00FF, 16'h0, 8'h08, 1'b0, 1'b0);
    sb.push_back({8'h08, 16'h00FF});
    chk("skid_ready_wait", 32'(o_ready), 32'h0);
    cyc(1); i_submit = 1'b0;
    chk("skid_ready_full", 32'(o_ready), 32'h0);
    chk("skid_no_early",   32'(o_reg_ie), 32'h0);
    cyc(1);
    i_mem_ack = 1'b1; i_mem_data = 16'h0A0A;
    cyc(1); i_mem_ack = 1'b0;
    chk("skid_ie_ld",    32'(o_reg_ie), 32'h01);
    chk("skid_ready_dr", 32'(o_ready),  32'h0);
    cyc(1);
    chk("skid_ie_alu",   32'(o_reg_ie), 32'h08);
    chk("skid_ready_up", 32'(o_ready),  32'h1);
    cyc(1);

    // Two loads back-to-back: second load reissues from the skid
    submit(16'h0, 16'h0040, 8'h20, 1'b1, 1'b0);
    sb.push_back({8'h20, 16'h1111});
    cyc(1);
    submit(16'h0, 16'h0050, 8'h40, 1'b1, 1'b0);
    sb.push_back({8'h40, 16'h2222});
    cyc(1); i_submit = 1'b0;
    chk("ll_addr1", 32'(o_mem_addr), 32'h0040);
    i_mem_ack = 1'b1; i_mem_data = 16'h1111;
    cyc(1); i_mem_ack = 1'b0;
    chk("ll_gap_req", 32'(o_mem_req), 32'h0);
    cyc(1);
    chk("ll_req2",  32'(o_mem_req),  32'h1);
    chk("ll_addr2", 32'(o_mem_addr), 32'h0050);
    i_mem_ack = 1'b1; i_mem_data = 16'h2222;
    cyc(1); i_mem_ack = 1'b0;
    cyc(1);
    chk("ll_ready", 32'(o_ready), 32'h1);

    // Reset mid-wait, then a late ack
    submit(16'h0, 16'h0300, 8'h04, 1'b1, 1'b0);
    cyc(1); i_submit = 1'b0;
    chk("rw_req", 32'(o_mem_req), 32'h1);
    i_rst = 1'b1;
    cyc(1); i_rst = 1'b0;
    chk("rw_req_drop", 32'(o_mem_req), 32'h0);
    chk("rw_ready",    32'(o_ready),   32'h1);
    i_mem_ack = 1'b1; i_mem_data = 16'hDEAD;
    cyc(1); i_mem_ack = 1'b0;
    chk("rw_no_wb",  32'(o_reg_ie),  32'h0);
    chk("rw_no_req", 32'(o_mem_req), 32'h0);

    // Stale ack while idle
    i_mem_ack = 1'b1; i_mem_data = 16'h7777;
    cyc(1); i_mem_ack = 1'b0;
    chk("stale_ie",    32'(o_reg_ie),   32'h0);
    chk("stale_data",  32'(o_reg_data), 32'h0);
    chk("stale_req",   32'(o_mem_req),  32'h0);
    chk("stale_ready", 32'(o_ready),    32'h1);

    cyc(3);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/memwb.md
Name: memwb

Overview:
- Memory/writeback stage; the downstream end of the execute → next-stage interface.
- Accepts one submitted op per cycle from execute and performs a load or store on the data-memory request/ack bus.
- Returns the writeback word and register write-enable mask to the register file.
- Drives the pipeline ready that throttles execute; a one-entry skid buffer absorbs the op already in flight when memory stalls.

Parameters:
RW, 16 (`RW), data/address word width
REGNO, 8 (`REGNO), number of registers; width of one-hot write-enable mask

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_data  in  RW  ALU result, or store data for memory ops
i_addr  in  RW  memory address
i_reg_ie  in  REGNO  one-hot destination register enable (0 = no writeback)
i_mem_access  in  1  op is a memory access
i_mem_we  in  1  memory access is a store
i_submit  in  1  op valid this cycle
o_ready  out  1  stage can accept an op submitted next cycle (to execute)
o_reg_ie  out  REGNO  register file write-enable, one-cycle pulse
o_reg_data  out  RW  writeback data
o_mem_req  out  1  memory request, held until ack
o_mem_we  out  1  request is a write
o_mem_addr  out  RW  request address
o_mem_data  out  RW  write data
i_mem_ack  in  1  memory completes current request this cycle
i_mem_data  in  RW  read data, valid with i_mem_ack on reads

Behaviour:
- Reset: state IDLE, skid_valid 0; all outputs 0 (o_mem_req, o_mem_we, o_mem_addr, o_mem_data, o_reg_ie, o_reg_data).
- o_ready = (state==IDLE) & ~skid_valid, combinational.
- Op source each cycle: the skid entry if skid_valid, else the i_* inputs when i_submit.
- States: IDLE, MEM_WAIT.
- IDLE, non-memory op:
  - Next edge: o_reg_ie <= i_reg_ie, o_reg_data <= i_data.
  - Latency 1 cycle; state remains IDLE.
- IDLE, memory op:
  - Next edge: o_mem_req <= 1; o_mem_addr, o_mem_we and o_mem_data latched; destination mask latched internally; state -> MEM_WAIT.
  - o_reg_ie <= 0.
- MEM_WAIT:
  - o_mem_req and all request fields held stable until a cycle with i_mem_ack=1.
  - On ack: o_mem_req <= 0, state -> IDLE.
  - Read: o_reg_data <= i_mem_data, o_reg_ie <= latched mask.
  - Write: o_reg_ie <= 0.
  - Ack may arrive in the first request cycle; minimum load latency is submit → o_reg_ie high 2 cycles later.
- o_reg_ie is high for exactly one cycle per writeback. It is 0 in every other cycle and for ops with i_reg_ie=0.
- Skid:
  - Capture occurs only when i_submit=1 while state==MEM_WAIT. This only happens the cycle after a memory op is accepted.
  - Captures data, addr, reg_ie, mem_access, mem_we; sets skid_valid.
  - A submit while skid_valid=1 is a protocol violation and cannot occur under the ready rule; flagged by an assertion.
  - Skid drains in the first IDLE cycle, with the same handling as a direct op; skid_valid clears on that edge.
- Ordering: ops complete strictly in submission order; the skid entry is always older than any later submit.
- i_mem_ack while IDLE is ignored (stale ack).
- Reset mid-operation:
  - Pending request abandoned; o_mem_req 0 on the next edge.
  - skid_valid cleared; no writeback issued for dropped ops.
  - A late ack after reset is ignored.
- Widths: no arithmetic; all fields pass through unchanged at RW/REGNO bits.

Decomposition:
- Shared config package: `RW, `REGNO, and the state encoding (MEMWB_IDLE=0, MEMWB_WAIT=1).
- Natural sub-module: memwb_skid, a one-entry op buffer with valid/load/drain.
- FSM and writeback registers stay in memwb.

Test Plan:
- ALU op: submit data=0x1234, reg_ie=0x04, mem_access=0 → next cycle o_reg_ie=0x04, o_reg_data=0x1234 for one cycle; o_mem_req stays 0.
- Load, 3-cycle ack: submit addr=0x0100, reg_ie=0x02; ack with i_mem_data=0xBEEF 3 cycles after o_mem_req rises → addr held 0x0100 throughout; then o_reg_ie=0x02, o_reg_data=0xBEEF one cycle; o_ready low during wait.
- Store, same-cycle ack: submit addr=0x0200, data=0x55AA, we=1 → o_mem_req one cycle, o_mem_we=1, o_mem_data=0x55AA; o_reg_ie stays 0.
- Back-to-back (skid): load (addr 0x10, reg_ie 0x01) then ALU op (0x00FF, reg_ie 0x08) the next cycle; ack after 2 cycles with 0x0A0A → writebacks in order: 0x01/0x0A0A, then 0x08/0x00FF the following cycle; o_ready returns high after skid drains.
- Reset mid-wait: load pending, assert i_rst one cycle, then ack → o_mem_req 0 after reset edge; no writeback; o_ready=1.
- Stale ack in IDLE: pulse i_mem_ack with no request → no output change.
